// File: rtl/german_system_param.sv
// German cache-coherence system with a configurable node count and data width.
// One rule attempt per cycle, live invariant monitors and a saturating step counter.
module german_system_param #(
    parameter int NODES   = 3,
    parameter int DATA_W  = 2,
    parameter int COUNT_W = 16,
    localparam int PTR_W  = (NODES > 1) ? $clog2(NODES) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_en_valid,
    input  logic [3:0]            io_en_rule,
    input  logic [PTR_W-1:0]      io_en_node,
    input  logic [DATA_W-1:0]     io_en_data,
    output logic                  io_guard,
    output logic [2*NODES-1:0]    io_cache_state,
    output logic [DATA_W*NODES-1:0] io_cache_data,
    output logic [NODES-1:0]      io_shr_set,
    output logic [NODES-1:0]      io_inv_set,
    output logic [2:0]            io_cur_cmd,
    output logic [PTR_W-1:0]      io_cur_ptr,
    output logic                  io_ex_gntd,
    output logic [DATA_W-1:0]     io_mem_data,
    output logic [DATA_W-1:0]     io_aux_data,
    output logic                  io_ctrl_ok,
    output logic                  io_data_ok,
    output logic                  io_err,
    output logic [COUNT_W-1:0]    io_steps
);

    typedef enum logic [2:0] {
        CMD_EMPTY  = 3'd0,
        CMD_REQS   = 3'd1,
        CMD_REQE   = 3'd2,
        CMD_INV    = 3'd3,
        CMD_INVACK = 3'd4,
        CMD_GNTS   = 3'd5,
        CMD_GNTE   = 3'd6
    } cmd_e;

    typedef enum logic [1:0] {
        ST_I = 2'd0,
        ST_S = 2'd1,
        ST_E = 2'd2
    } cst_e;

    localparam logic [3:0] R_SEND_REQS   = 4'd0;
    localparam logic [3:0] R_SEND_REQE   = 4'd1;
    localparam logic [3:0] R_RECV_REQS   = 4'd2;
    localparam logic [3:0] R_RECV_REQE   = 4'd3;
    localparam logic [3:0] R_SEND_INV    = 4'd4;
    localparam logic [3:0] R_SEND_INVACK = 4'd5;
    localparam logic [3:0] R_RECV_INVACK = 4'd6;
    localparam logic [3:0] R_SEND_GNTS   = 4'd7;
    localparam logic [3:0] R_SEND_GNTE   = 4'd8;
    localparam logic [3:0] R_RECV_GNTS   = 4'd9;
    localparam logic [3:0] R_RECV_GNTE   = 4'd10;
    localparam logic [3:0] R_STORE       = 4'd11;

    cst_e              r_cs  [NODES];
    logic [DATA_W-1:0] r_cd  [NODES];
    cmd_e              r_c1  [NODES];
    cmd_e              r_c2  [NODES];
    logic [DATA_W-1:0] r_c2d [NODES];
    cmd_e              r_c3  [NODES];
    logic [DATA_W-1:0] r_c3d [NODES];

    logic [NODES-1:0]   r_shr;
    logic [NODES-1:0]   r_inv;
    cmd_e               r_cur_cmd;
    logic [PTR_W-1:0]   r_cur_ptr;
    logic               r_exg;
    logic [DATA_W-1:0]  r_mem;
    logic [DATA_W-1:0]  r_aux;
    logic               r_err;
    logic [COUNT_W-1:0] r_steps;

    logic              w_node_ok;
    logic [PTR_W-1:0]  w_i;
    cst_e              w_cs;
    logic [DATA_W-1:0] w_cd;
    cmd_e              w_c1;
    cmd_e              w_c2;
    logic [DATA_W-1:0] w_c2d;
    cmd_e              w_c3;
    logic [DATA_W-1:0] w_c3d;
    logic              w_rule_ok;
    logic              w_fire;
    logic              w_ctrl_ok;
    logic              w_data_ok;

    // Out-of-range nodes are clamped to 0 for lookup; they never fire anyway.
    assign w_node_ok = (int'(io_en_node) < NODES);
    assign w_i       = w_node_ok ? io_en_node : '0;

    assign w_cs  = r_cs[w_i];
    assign w_cd  = r_cd[w_i];
    assign w_c1  = r_c1[w_i];
    assign w_c2  = r_c2[w_i];
    assign w_c2d = r_c2d[w_i];
    assign w_c3  = r_c3[w_i];
    assign w_c3d = r_c3d[w_i];

    always_comb begin
        w_rule_ok = 1'b0;
        case (io_en_rule)
            R_SEND_REQS:
                w_rule_ok = (w_c1 == CMD_EMPTY) && (w_cs == ST_I);
            R_SEND_REQE:
                w_rule_ok = (w_c1 == CMD_EMPTY) &&
                            ((w_cs == ST_I) || (w_cs == ST_S));
            R_RECV_REQS:
                w_rule_ok = (r_cur_cmd == CMD_EMPTY) && (w_c1 == CMD_REQS);
            R_RECV_REQE:
                w_rule_ok = (r_cur_cmd == CMD_EMPTY) && (w_c1 == CMD_REQE);
            R_SEND_INV:
                w_rule_ok = (w_c2 == CMD_EMPTY) && r_inv[w_i] &&
                            ((r_cur_cmd == CMD_REQE) ||
                             ((r_cur_cmd == CMD_REQS) && r_exg));
            R_SEND_INVACK:
                w_rule_ok = (w_c2 == CMD_INV) && (w_c3 == CMD_EMPTY);
            R_RECV_INVACK:
                w_rule_ok = (w_c3 == CMD_INVACK) && (r_cur_cmd != CMD_EMPTY);
            R_SEND_GNTS:
                w_rule_ok = (r_cur_cmd == CMD_REQS) && (r_cur_ptr == w_i) &&
                            (w_c2 == CMD_EMPTY) && !r_exg;
            R_SEND_GNTE:
                w_rule_ok = (r_cur_cmd == CMD_REQE) && (r_cur_ptr == w_i) &&
                            (w_c2 == CMD_EMPTY) && !r_exg && (r_shr == '0);
            R_RECV_GNTS:
                w_rule_ok = (w_c2 == CMD_GNTS);
            R_RECV_GNTE:
                w_rule_ok = (w_c2 == CMD_GNTE);
            R_STORE:
                w_rule_ok = (w_cs == ST_E);
            default:
                w_rule_ok = 1'b0;
        endcase
    end

    assign w_fire = io_en_valid && w_node_ok && w_rule_ok;

    always_comb begin
        w_ctrl_ok = 1'b1;
        w_data_ok = r_exg || (r_mem == r_aux);
        for (int a = 0; a < NODES; a++) begin
            if ((r_cs[a] != ST_I) && (r_cd[a] != r_aux)) begin
                w_data_ok = 1'b0;
            end
            for (int b = 0; b < NODES; b++) begin
                if ((a != b) && (r_cs[a] == ST_E) && (r_cs[b] != ST_I)) begin
                    w_ctrl_ok = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int n = 0; n < NODES; n++) begin
                r_cs[n]  <= ST_I;
                r_cd[n]  <= '0;
                r_c1[n]  <= CMD_EMPTY;
                r_c2[n]  <= CMD_EMPTY;
                r_c2d[n] <= '0;
                r_c3[n]  <= CMD_EMPTY;
                r_c3d[n] <= '0;
            end
            r_shr     <= '0;
            r_inv     <= '0;
            r_cur_cmd <= CMD_EMPTY;
            r_cur_ptr <= '0;
            r_exg     <= 1'b0;
            r_mem     <= '0;
            r_aux     <= '0;
            r_err     <= 1'b0;
            r_steps   <= '0;
        end else begin
            r_err <= r_err | ~(w_ctrl_ok & w_data_ok);
            if (w_fire) begin
                if (r_steps != '1) begin
                    r_steps <= r_steps + 1'b1;
                end
                case (io_en_rule)
                    R_SEND_REQS: r_c1[w_i] <= CMD_REQS;
                    R_SEND_REQE: r_c1[w_i] <= CMD_REQE;
                    R_RECV_REQS, R_RECV_REQE: begin
                        r_cur_cmd <= w_c1;
                        r_cur_ptr <= w_i;
                        r_c1[w_i] <= CMD_EMPTY;
                        r_inv     <= r_shr;
                    end
                    R_SEND_INV: begin
                        r_c2[w_i]  <= CMD_INV;
                        r_inv[w_i] <= 1'b0;
                    end
                    R_SEND_INVACK: begin
                        r_c2[w_i] <= CMD_EMPTY;
                        r_c3[w_i] <= CMD_INVACK;
                        if (w_cs == ST_E) begin
                            r_c3d[w_i] <= w_cd;
                        end
                        r_cs[w_i] <= ST_I;
                        r_cd[w_i] <= '0;
                    end
                    R_RECV_INVACK: begin
                        r_c3[w_i]  <= CMD_EMPTY;
                        r_shr[w_i] <= 1'b0;
                        if (r_exg) begin
                            r_exg <= 1'b0;
                            r_mem <= w_c3d;
                        end
                    end
                    R_SEND_GNTS: begin
                        r_c2[w_i]  <= CMD_GNTS;
                        r_c2d[w_i] <= r_mem;
                        r_shr[w_i] <= 1'b1;
                        r_cur_cmd  <= CMD_EMPTY;
                    end
                    R_SEND_GNTE: begin
                        r_c2[w_i]  <= CMD_GNTE;
                        r_c2d[w_i] <= r_mem;
                        r_shr[w_i] <= 1'b1;
                        r_cur_cmd  <= CMD_EMPTY;
                        r_exg      <= 1'b1;
                    end
                    R_RECV_GNTS: begin
                        r_cs[w_i] <= ST_S;
                        r_cd[w_i] <= w_c2d;
                        r_c2[w_i] <= CMD_EMPTY;
                    end
                    R_RECV_GNTE: begin
                        r_cs[w_i] <= ST_E;
                        r_cd[w_i] <= w_c2d;
                        r_c2[w_i] <= CMD_EMPTY;
                    end
                    R_STORE: begin
                        r_cd[w_i] <= io_en_data;
                        r_aux     <= io_en_data;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_comb begin
        io_cache_state = '0;
        io_cache_data  = '0;
        for (int n = 0; n < NODES; n++) begin
            io_cache_state[2*n +: 2]           = r_cs[n];
            io_cache_data[DATA_W*n +: DATA_W] = r_cd[n];
        end
    end

    assign io_guard    = w_fire;
    assign io_shr_set  = r_shr;
    assign io_inv_set  = r_inv;
    assign io_cur_cmd  = r_cur_cmd;
    assign io_cur_ptr  = r_cur_ptr;
    assign io_ex_gntd  = r_exg;
    assign io_mem_data = r_mem;
    assign io_aux_data = r_aux;
    assign io_ctrl_ok  = w_ctrl_ok;
    assign io_data_ok  = w_data_ok;
    assign io_err      = r_err;
    assign io_steps    = r_steps;

endmodule

// File: tb/tb_german_system_param.sv
// Directed and random bench for german_system_param, 3 nodes with 2-bit data.
// A second instance with a 4-bit step counter shares the stimulus.
module tb_german_system_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] rule = '0;
    logic [1:0] node = '0;
    logic [1:0] data = '0;

    logic        g_a, g_b;
    logic [5:0]  cs_a, cs_b, cd_a, cd_b;
    logic [2:0]  shr_a, shr_b, inv_a, inv_b, cur_a, cur_b;
    logic [1:0]  ptr_a, ptr_b;
    logic        exg_a, exg_b;
    logic [1:0]  mem_a, mem_b, aux_a, aux_b;
    logic        cok_a, cok_b, dok_a, dok_b, err_a, err_b;
    logic [15:0] steps_a;
    logic [3:0]  steps_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    german_system_param #(.NODES(3), .DATA_W(2), .COUNT_W(16)) dut (
        .clock(clk), .reset(rst_n),
        .io_en_valid(valid), .io_en_rule(rule),
        .io_en_node(node), .io_en_data(data),
        .io_guard(g_a), .io_cache_state(cs_a), .io_cache_data(cd_a),
        .io_shr_set(shr_a), .io_inv_set(inv_a), .io_cur_cmd(cur_a),
        .io_cur_ptr(ptr_a), .io_ex_gntd(exg_a), .io_mem_data(mem_a),
        .io_aux_data(aux_a), .io_ctrl_ok(cok_a), .io_data_ok(dok_a),
        .io_err(err_a), .io_steps(steps_a)
    );

    german_system_param #(.NODES(3), .DATA_W(2), .COUNT_W(4)) dut4 (
        .clock(clk), .reset(rst_n),
        .io_en_valid(valid), .io_en_rule(rule),
        .io_en_node(node), .io_en_data(data),
        .io_guard(g_b), .io_cache_state(cs_b), .io_cache_data(cd_b),
        .io_shr_set(shr_b), .io_inv_set(inv_b), .io_cur_cmd(cur_b),
        .io_cur_ptr(ptr_b), .io_ex_gntd(exg_b), .io_mem_data(mem_b),
        .io_aux_data(aux_b), .io_ctrl_ok(cok_b), .io_data_ok(dok_b),
        .io_err(err_b), .io_steps(steps_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [1:0] n,
                        input logic [1:0] d, input logic g, input string tag);
        @(negedge clk);
        valid = 1'b1;
        rule  = r;
        node  = n;
        data  = d;
        #1;
        chk(tag, {31'd0, g_a}, {31'd0, g});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'b1;
        rule  = 4'd0;
        node  = 2'd0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_cs", cs_a, 0);
        chk("rst_cd", cd_a, 0);
        chk("rst_shr", shr_a, 0);
        chk("rst_inv", inv_a, 0);
        chk("rst_cur", cur_a, 0);
        chk("rst_ptr", ptr_a, 0);
        chk("rst_exg", exg_a, 0);
        chk("rst_mem", mem_a, 0);
        chk("rst_aux", aux_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_steps", steps_a, 0);
        chk("rst_steps4", steps_b, 0);

        step(4'd0, 2'd1, 2'd0, 1'b1, "n1_reqs");
        step(4'd2, 2'd1, 2'd0, 1'b1, "n1_recvreqs");
        step(4'd7, 2'd1, 2'd0, 1'b1, "n1_gnts");
        step(4'd9, 2'd1, 2'd0, 1'b1, "n1_recvgnts");
        chk("n1_cs", cs_a, 6'b000100);
        chk("n1_cd", cd_a, 0);
        chk("n1_shr", shr_a, 3'b010);
        chk("n1_cur", cur_a, 0);
        chk("n1_steps", steps_a, 4);
        chk("n1_ctrl", cok_a, 1);
        chk("n1_data", dok_a, 1);

        step(4'd1, 2'd0, 2'd0, 1'b1, "n0_reqe_a");
        step(4'd3, 2'd0, 2'd0, 1'b1, "n0_recvreqe_a");
        chk("n0_inv_a", inv_a, 3'b010);
        chk("n0_cur_a", cur_a, 2);
        step(4'd8, 2'd0, 2'd0, 1'b0, "gnte_blocked_shr");
        chk("blk_steps", steps_a, 6);

        do_reset();
        step(4'd1, 2'd0, 2'd0, 1'b1, "n0_reqe");
        step(4'd3, 2'd0, 2'd0, 1'b1, "n0_recvreqe");
        step(4'd8, 2'd0, 2'd0, 1'b1, "n0_gnte");
        step(4'd10, 2'd0, 2'd0, 1'b1, "n0_recvgnte");
        step(4'd11, 2'd0, 2'd2, 1'b1, "n0_store");
        chk("st_aux", aux_a, 2);
        chk("st_mem", mem_a, 0);
        chk("st_exg", exg_a, 1);
        chk("st_data_ok", dok_a, 1);
        chk("st_cs", cs_a, 6'b000010);
        chk("st_cd", cd_a, 6'b000010);
        chk("st_shr", shr_a, 3'b001);
        chk("st_steps", steps_a, 5);

        step(4'd0, 2'd2, 2'd0, 1'b1, "n2_reqs");
        step(4'd2, 2'd2, 2'd0, 1'b1, "n2_recvreqs");
        step(4'd4, 2'd0, 2'd0, 1'b1, "n0_inv");
        step(4'd5, 2'd0, 2'd0, 1'b1, "n0_invack");
        step(4'd6, 2'd0, 2'd0, 1'b1, "n0_recvinvack");
        chk("wb_mem", mem_a, 2);
        chk("wb_exg", exg_a, 0);
        chk("wb_cs", cs_a, 0);
        chk("wb_cd", cd_a, 0);
        chk("wb_cur", cur_a, 1);
        chk("wb_ptr", ptr_a, 2);
        chk("wb_steps", steps_a, 10);

        step(4'd7, 2'd2, 2'd0, 1'b1, "n2_gnts");
        step(4'd9, 2'd2, 2'd0, 1'b1, "n2_recvgnts");
        chk("n2_cs", cs_a, 6'b010000);
        chk("n2_cd", cd_a, 6'b100000);
        chk("n2_shr", shr_a, 3'b100);
        chk("n2_cur", cur_a, 0);
        chk("n2_steps", steps_a, 12);
        chk("n2_steps4", steps_b, 12);

        step(4'd10, 2'd0, 2'd0, 1'b0, "rej_recvgnte");
        step(4'd11, 2'd1, 2'd3, 1'b0, "rej_store_i");
        step(4'd0, 2'd3, 2'd0, 1'b0, "rej_node3");
        step(4'd13, 2'd0, 2'd0, 1'b0, "rej_rule13");
        step(4'd8, 2'd2, 2'd0, 1'b0, "rej_gnte_empty");
        chk("rej_steps", steps_a, 12);
        chk("rej_cs", cs_a, 6'b010000);
        chk("rej_cd", cd_a, 6'b100000);
        chk("rej_aux", aux_a, 2);
        chk("rej_shr", shr_a, 3'b100);

        do_reset();
        step(4'd1, 2'd0, 2'd0, 1'b1, "sat_reqe");
        step(4'd3, 2'd0, 2'd0, 1'b1, "sat_recvreqe");
        step(4'd8, 2'd0, 2'd0, 1'b1, "sat_gnte");
        step(4'd10, 2'd0, 2'd0, 1'b1, "sat_recvgnte");
        for (int i = 0; i < 16; i++) begin
            step(4'd11, 2'd0, 2'(i), 1'b1, "sat_store");
        end
        chk("sat_steps16", steps_a, 20);
        chk("sat_steps4", steps_b, 15);
        chk("sat_aux", aux_a, 3);
        chk("sat_cd", cd_a, 6'b000011);

        do_reset();
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            valid = 1'($urandom_range(0, 1));
            rule  = 4'($urandom_range(0, 15));
            node  = 2'($urandom_range(0, 3));
            data  = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            if (!(cok_a && dok_a)) begin
                chk("rnd_props", {30'd0, cok_a, dok_a}, 3);
            end
        end
        @(negedge clk);
        valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rnd_err", err_a, 0);
        chk("rnd_err4", err_b, 0);
        chk("rnd_ctrl", cok_a, 1);
        chk("rnd_data", dok_a, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
